lag_pl_rx_buffer: RTL and testbench

- Receive end of a physical output link: one per router input port.
- Accepts flits tagged with a PL id and stores each in that PL's FIFO.
- Presents the head of each FIFO to the local switch, and returns per-PL credits and empty status upstream.
- Upstream, the free-PL tracker uses `pl_empty` and the tail-flit stream to recycle PLs; this block is the consumer side of that protocol.

---
 rtl/lag_pl_rx_buffer_pkg.sv | 13 +
 rtl/lag_pl_rx_fifo.sv | 34 +++
 rtl/lag_pl_rx_buffer.sv | 73 +++++++
 tb/tb_lag_pl_rx_buffer.sv | 109 ++++++++++
 4 files changed

// File: rtl/lag_pl_rx_buffer_pkg.sv
// lag_pl_rx_buffer_pkg: shared link constants, PL id and flit record types
package lag_pl_rx_buffer_pkg;
  localparam int NUM_PLS = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FLIT_W = 32;
  localparam int PLID_W = $clog2(NUM_PLS);
  typedef logic [PLID_W-1:0] pl_id_t;
  typedef struct packed {
    logic head;
    logic tail;
    logic [FLIT_W-1:0] data;
  } flit_t;
endpackage

// File: rtl/lag_pl_rx_fifo.sv
// lag_pl_rx_fifo: single-PL wrap-bit circular FIFO (wr_en/wr_data in, rd_en pop, FWFT rd_data, empty/full/count out)
module lag_pl_rx_fifo #(
  parameter int depth = 4,
  parameter int w = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [w-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [w-1:0]             rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(depth):0]   count
);
  localparam int aw = $clog2(depth);
  logic [w-1:0] mem [depth];
  logic [aw:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[aw] != rd[aw]) && (wr[aw-1:0] == rd[aw-1:0]);
  assign count = wr - rd;
  assign rd_data = mem[rd[aw-1:0]];
  always_ff @(posedge clk)
    if (wr_en && !full) mem[wr[aw-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (wr_en && !full) wr <= wr + 1'b1;
      if (rd_en && !empty) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/lag_pl_rx_buffer.sv
// lag_pl_rx_buffer: per-PL receive FIFOs with framing check (in_* link flit, out_*/deq to switch, credit_out/pl_empty upstream, sticky err_ovf/err_proto)
module lag_pl_rx_buffer
  import lag_pl_rx_buffer_pkg::*;
#(
  parameter int num_pls = NUM_PLS,
  parameter int fifo_depth = FIFO_DEPTH,
  parameter int flit_w = FLIT_W,
  parameter int plid_w = PLID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [plid_w-1:0]         in_pl,
  input  logic                      in_head,
  input  logic                      in_tail,
  input  logic [flit_w-1:0]         in_data,
  output logic [num_pls-1:0]        out_valid,
  output logic [num_pls-1:0]        out_head,
  output logic [num_pls-1:0]        out_tail,
  output logic [num_pls*flit_w-1:0] out_data,
  input  logic [num_pls-1:0]        deq,
  output logic [num_pls-1:0]        credit_out,
  output logic [num_pls-1:0]        pl_empty,
  output logic                      err_ovf,
  output logic                      err_proto
);
  localparam logic IDLE = 1'b0;
  localparam logic IN_PKT = 1'b1;
  logic [num_pls-1:0] wr_en, full, empty, acc, pop, st, st_n, proto;
  logic [flit_w+1:0] rd_data [num_pls];
  logic [$clog2(fifo_depth):0] count [num_pls];
  logic pl_ok;
  assign pl_ok = 32'(in_pl) < num_pls;
  genvar i;
  generate
    for (i = 0; i < num_pls; i++) begin : g_pl
      assign wr_en[i] = in_valid && pl_ok && (in_pl == plid_w'(i));
      assign acc[i] = wr_en[i] && !full[i];
      assign pop[i] = deq[i] && !empty[i];
      assign proto[i] = acc[i] && (st[i] == IDLE ? !in_head : in_head);
      assign st_n[i] = !acc[i] ? st[i] : in_head ? (in_tail ? IDLE : IN_PKT) : (in_tail ? IDLE : st[i]);
      lag_pl_rx_fifo #(.depth(fifo_depth), .w(flit_w + 2)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en[i]),
        .wr_data({in_head, in_tail, in_data}),
        .rd_en(deq[i]),
        .rd_data(rd_data[i]),
        .empty(empty[i]),
        .full(full[i]),
        .count(count[i])
      );
      assign out_valid[i] = !empty[i];
      assign out_head[i] = rd_data[i][flit_w+1];
      assign out_tail[i] = rd_data[i][flit_w];
      assign out_data[i*flit_w +: flit_w] = rd_data[i][flit_w-1:0];
      assign pl_empty[i] = count[i] == '0;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= {num_pls{IDLE}};
      credit_out <= '0;
      err_ovf <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      st <= st_n;
      credit_out <= pop;
      err_ovf <= err_ovf | |(wr_en & full);
      err_proto <= err_proto | |proto | (in_valid && !pl_ok);
    end
  end
endmodule

// File: tb/tb_lag_pl_rx_buffer.sv
// tb_lag_pl_rx_buffer: scoreboard bench for lag_pl_rx_buffer
module tb_lag_pl_rx_buffer;
  import lag_pl_rx_buffer_pkg::*;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_head = 0, in_tail = 0;
  logic [1:0] in_pl = 0;
  logic [31:0] in_data = 0;
  logic [3:0] out_valid, out_head, out_tail, deq = 0, credit_out, pl_empty;
  logic [127:0] out_data;
  logic err_ovf, err_proto;
  int checks = 0, failures = 0;
  flit_t q [4][$];
  logic [3:0] m_cr = 0, m_st = 0;
  logic m_ovf = 0, m_proto = 0;
  always #5 clk = ~clk;
  lag_pl_rx_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pl(in_pl), .in_head(in_head),
    .in_tail(in_tail), .in_data(in_data), .out_valid(out_valid), .out_head(out_head),
    .out_tail(out_tail), .out_data(out_data), .deq(deq), .credit_out(credit_out),
    .pl_empty(pl_empty), .err_ovf(err_ovf), .err_proto(err_proto)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h @%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic tick(input logic v, input logic [1:0] pl, input logic h, input logic t,
                      input logic [31:0] d, input logic [3:0] dq, input logic r);
    logic [3:0] cr;
    flit_t f;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("valid%0d", i), 64'(out_valid[i]), 64'(q[i].size() > 0));
      check($sformatf("empty%0d", i), 64'(pl_empty[i]), 64'(q[i].size() == 0));
      check($sformatf("credit%0d", i), 64'(credit_out[i]), 64'(m_cr[i]));
      if (q[i].size() > 0)
        check($sformatf("front%0d", i), 64'({out_head[i], out_tail[i], out_data[i*32 +: 32]}), 64'(q[i][0]));
    end
    check("err_ovf", 64'(err_ovf), 64'(m_ovf));
    check("err_proto", 64'(err_proto), 64'(m_proto));
    rst = r; in_valid = v; in_pl = pl; in_head = h; in_tail = t; in_data = d; deq = dq;
    if (r) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      m_cr = 0; m_st = 0; m_ovf = 0; m_proto = 0;
    end else begin
      for (int i = 0; i < 4; i++) cr[i] = dq[i] && q[i].size() > 0;
      if (v) begin
        if (q[pl].size() == 4) m_ovf = 1;
        else begin
          if (m_st[pl] ? h : !h) m_proto = 1;
          m_st[pl] = h ? !t : (t ? 1'b0 : m_st[pl]);
          f.head = h; f.tail = t; f.data = d;
          q[pl].push_back(f);
        end
      end
      for (int i = 0; i < 4; i++) if (cr[i]) void'(q[i].pop_front());
      m_cr = cr;
    end
    @(posedge clk);
  endtask
  task automatic idle(input logic [3:0] dq);
    tick(0, 0, 0, 0, 0, dq, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    rst = 0;
    idle(0);
    tick(1, 2, 1, 1, 32'hC0DE_0002, 0, 0);
    idle(4'b0100);
    idle(0);
    idle(0);
    tick(1, 0, 1, 0, 32'hA000_0000, 0, 0);
    tick(1, 0, 0, 0, 32'hA000_0001, 0, 0);
    tick(1, 0, 0, 0, 32'hA000_0002, 0, 0);
    tick(1, 0, 0, 1, 32'hA000_0003, 0, 0);
    tick(1, 0, 1, 1, 32'hA000_0004, 0, 0);
    repeat (5) idle(4'b0001);
    idle(0);
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, k == 0, k == 2, 32'hB100_0000 + k, 0, 0);
      tick(1, 3, k == 0, k == 2, 32'hB300_0000 + k, 0, 0);
    end
    repeat (4) idle(4'b1010);
    tick(1, 1, 1, 0, 32'hD000_0000, 0, 0);
    tick(1, 1, 0, 0, 32'hD000_0001, 0, 0);
    tick(1, 1, 0, 1, 32'hD000_0002, 4'b1010, 0);
    idle(0);
    repeat (3) idle(4'b0010);
    tick(1, 0, 0, 0, 32'hE000_0000, 0, 0);
    tick(1, 0, 1, 0, 32'hE000_0001, 0, 0);
    tick(1, 0, 1, 1, 32'hE000_0002, 0, 0);
    tick(1, 0, 0, 1, 32'hE000_0003, 4'b0001, 0);
    repeat (4) idle(4'b0001);
    tick(1, 1, 1, 0, 32'hF000_0001, 0, 0);
    tick(1, 2, 1, 0, 32'hF000_0002, 0, 0);
    tick(0, 0, 0, 0, 0, 4'b0010, 1);
    idle(0);
    idle(0);
    for (int k = 0; k < 400; k++)
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), k == 200);
    repeat (6) idle(4'b1111);
    idle(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
